// File: rtl/alu_result_packer.sv
// ALU result packer: buffers 16-bit results, streams them out LSB byte first.
// Optional ALU_PACK_OVF_EN adds a sticky dropped-result flag (OVF/OVF_CLR).
module alu_result_packer #(
  parameter int DATA_WIDTH = 16,
  parameter int BYTE_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  OUT_Valid,
  output logic [BYTE_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  FIFO_FULL,
  output logic                  BUSY,
  input  logic                  OVF_CLR,
  output logic                  OVF
);

  localparam int NBYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [IW-1:0] LAST_C = IW'(NBYTES - 1);

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;

  logic hs;
  logic last;
  logic not_empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign TX_VALID  = (state_q == S_SEND);
  assign full      = (count_q == DEPTH_C);
  assign FIFO_FULL = full;
  assign BUSY      = (count_q != '0) || (state_q != S_IDLE);

  // Serialiser next state, head pop, and FIFO push/drop decision
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    word_d    = word_q;
    pop       = 1'b0;
    hs        = TX_VALID && TX_READY;
    last      = (idx_q == LAST_C);
    not_empty = (count_q != '0);
    case (state_q)
      S_IDLE: begin
        if (not_empty) begin
          pop     = 1'b1;
          word_d  = mem_q[rd_ptr_q];
          idx_d   = '0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (hs) begin
          if (!last) begin
            idx_d = idx_q + IW'(1);
          end else if (not_empty) begin
            pop    = 1'b1;
            word_d = mem_q[rd_ptr_q];
            idx_d  = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    push = OUT_Valid && !RST && (!full || pop);
    drop = OUT_Valid && !RST && full && !pop;
  end

  // Pointer and occupancy bookkeeping
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
  end

  // Current byte of the word under transmission; zero when idle
  always_comb begin
    TX_DATA = '0;
    if (state_q == S_SEND) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (idx_q == IW'(i)) begin
          TX_DATA = word_q[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // FIFO storage; contents need no reset since pointers define validity
  always_ff @(posedge CLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= ALU_OUT;
    end
  end

  // Control state register with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      idx_q    <= '0;
      word_q   <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      idx_q    <= idx_d;
      word_q   <= word_d;
    end
  end

`ifdef ALU_PACK_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky drop flag; a drop in the same cycle as a clear keeps it set
  always_comb begin
    ovf_d = ovf_q;
    if (OVF_CLR) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  // Drop flag register
  always_ff @(posedge CLK) begin
    if (RST) ovf_q <= 1'b0;
    else     ovf_q <= ovf_d;
  end

  assign OVF = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = OVF_CLR | drop;
  assign OVF = 1'b0;
`endif

endmodule
